pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Parametrised game-control state machine for the Pong design. It sits between the button inputs, `vga_sync`/`pong_graph` and the score/colour logic in the top level. It sequences new-game, serve, play and game-over phases, tracks remaining balls and per-player scores, and freezes graphics while no ball is in flight. Compared with the previous fixed three-state controller, it adds configurable lives, a win score, per-side miss scoring, a timed game-over hold and an optional auto-serve.

## Interface
- `BALLS`, 3: balls per game; range 1..15.
- `SCORE_W`, 4: width of each score counter.
- `WIN_SCORE`, 9: score that ends the game; must be < 2^SCORE_W.
- `OVER_CYCLES`, 100_000_000: clocks spent in OVER before returning to NEWGAME; must be ≥ 1.
- `SERVE_CYCLES`, 150_000_000: auto-serve delay; used only with `PONG_AUTO_SERVE_EN`.
- `clk  in  1`: system clock; all logic on rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `btn1  in  2`: player-1 buttons, raw level, already debounced.
- `btn2  in  2`: player-2 buttons, raw level, already debounced.
- `hit  in  1`: one-cycle pulse from `pong_graph`, ball hit a paddle.
- `miss_l  in  1`: one-cycle pulse, ball passed the left paddle. Scores for player 2.
- `miss_r  in  1`: one-cycle pulse, ball passed the right paddle. Scores for player 1.
- `state  out  2`: current state encoding from the package.
- `gra_still  out  1`: 1 freezes the ball in `pong_graph`.
- `score1`, `score2`  out  SCORE_W: player scores.
- `balls_left  out  4`: remaining balls.
- `winner  out  2`: 00 none, 01 player 1, 10 player 2, 11 tie. Valid in OVER.
- `hit_cnt  out  8`: rally hit count, saturating at 255.

## Operation
- States: NEWGAME, SERVE, PLAY, OVER.
- Start event: rising edge on any bit of `btn1` or `btn2`, detected against the previous-cycle value. A held button never generates a second start.
- NEWGAME:
  - `gra_still`=1.
  - On a start event, clear both scores and `hit_cnt`, load `balls_left`=BALLS, and go to PLAY.
- PLAY:
  - `gra_still`=0.
  - `hit` increments `hit_cnt` (saturating).
  - Miss handling:
    - `miss_l` increments `score2` (saturating at 2^SCORE_W−1).
    - `miss_r` increments `score1`.
    - Any miss decrements `balls_left` by exactly 1, including when both misses arrive in the same cycle; both scores still increment.
  - Exit after any miss:
    - To OVER if `balls_left` becomes 0 or either updated score reaches ≥ WIN_SCORE.
    - Otherwise to SERVE, with `hit_cnt` cleared.
- SERVE:
  - `gra_still`=1.
  - On a start event, go to PLAY.
- OVER:
  - `gra_still`=1.
  - The hold timer counts from 0; when it reaches OVER_CYCLES−1, go to NEWGAME.
  - `winner` is computed by comparing `score1` and `score2`.
  - Buttons are ignored.
- Priority in PLAY: a miss overrides a `hit` in the same cycle; the `hit` is dropped.
- Pulses on `hit`/`miss_*` outside PLAY are ignored.
- Reset:
  - State NEWGAME, `gra_still`=1.
  - Scores, `hit_cnt`, `winner` and timers = 0.
  - `balls_left`=BALLS.
  - The button history register is loaded with 0, so a button held through reset produces a start event on the first cycle after reset.
  - Reset mid-game discards everything above; no partial state survives.

## Timing
- All outputs are registered.
- An input event in cycle N is visible on the outputs in cycle N+1.
- Start event: the button rises in cycle N, edge detection registers it in N+1, and `state`=PLAY in N+2.
- The OVER dwell is exactly OVER_CYCLES clocks.
- The score update, `balls_left` update and state change happen in the same cycle.

## Configuration
- `PONG_AUTO_SERVE_EN` defined:
  - SERVE also counts clocks and enters PLAY automatically after SERVE_CYCLES clocks with no start event.
  - A start event before that serves immediately.
  - The counter clears on every entry to SERVE.
- Undefined: SERVE waits for a button indefinitely; the serve counter and `SERVE_CYCLES` logic are not generated.

## Structure
- `pong_pkg`:
  - State localparams (NEWGAME=2'b00, PLAY=2'b01, SERVE=2'b10, OVER=2'b11).
  - `winner` encodings.
- Sub-module `btn_edge`: parametrised width, per-bit rising-edge detector with a synchronous reset. Instantiated once over the 4-bit concatenation {btn2,btn1}.
- Counter widths are derived with `$clog2` of OVER_CYCLES and SERVE_CYCLES.

## Test plan
- Reset held with `btn1`=01, then released: state=NEWGAME and `balls_left`=3 after reset; state=PLAY two cycles after release. Then hold the button with no miss: no further transition.
- Full game, BALLS=3, WIN_SCORE=9: press, `miss_l` ×3 with a press between each. Expect `score2`=3, `balls_left` 3→2→1→0, OVER after the third miss, `winner`=10.
- WIN_SCORE=2, BALLS=5: `miss_r` twice. Expect OVER with `score1`=2, `balls_left`=3, `winner`=01.
- Simultaneous `miss_l`+`miss_r`+`hit` in one PLAY cycle. Expect `score1`=1, `score2`=1, `balls_left`=BALLS−1, `hit_cnt` unchanged then cleared in SERVE.
- OVER_CYCLES=10: measure the OVER dwell = 10 clocks, with button presses during OVER ignored. Then NEWGAME is entered and a new press restarts with scores cleared.
- With `PONG_AUTO_SERVE_EN`, SERVE_CYCLES=20: SERVE enters PLAY after exactly 20 clocks with no button. A press at clock 5 enters PLAY 2 cycles later.

Source files
------------

// File: rtl/pong_game_ctrl_pkg.sv
// Shared state and winner encodings for the Pong game controller.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_SERVE   = 2'b10,
        ST_OVER    = 2'b11
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    function automatic logic [1:0] judge_winner(input logic [15:0] s1, input logic [15:0] s2);
        if (s1 > s2) begin
            return WIN_P1;
        end else if (s2 > s1) begin
            return WIN_P2;
        end else begin
            return WIN_TIE;
        end
    endfunction

endpackage

// File: rtl/pong_game_ctrl_btn_edge.sv
// Registered per-bit rising-edge detector; history clears to 0 so a held
// button reports an edge right after reset.
module btn_edge #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] btn_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] prev_q;
    logic [W-1:0] rise_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            rise_q <= '0;
        end else begin
            prev_q <= btn_i;
            rise_q <= btn_i & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: new-game / serve / play / game-over with lives and scores.
// Define PONG_AUTO_SERVE_EN to make SERVE launch the ball after SERVE_CYCLES.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BALLS        = 3,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int OVER_CYCLES  = 100_000_000,
    parameter int SERVE_CYCLES = 150_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         btn1,
    input  logic [1:0]         btn2,
    input  logic               hit,
    input  logic               miss_l,
    input  logic               miss_r,
    output logic [1:0]         state,
    output logic               gra_still,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [3:0]         balls_left,
    output logic [1:0]         winner,
    output logic [7:0]         hit_cnt
);

    localparam int OVER_W = (OVER_CYCLES > 1) ? $clog2(OVER_CYCLES) : 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);

    logic [3:0]         rise_s;
    logic               start_s;
    logic               miss_s;
    logic               end_game_s;
    logic [SCORE_W-1:0] score1_d;
    logic [SCORE_W-1:0] score2_d;
    logic [3:0]         balls_d;

    state_e             state_q;
    logic               gra_still_q;
    logic [SCORE_W-1:0] score1_q;
    logic [SCORE_W-1:0] score2_q;
    logic [3:0]         balls_q;
    logic [1:0]         winner_q;
    logic [7:0]         hit_cnt_q;
    logic [OVER_W-1:0]  over_q;
`ifdef PONG_AUTO_SERVE_EN
    localparam int SERVE_W = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
    logic [SERVE_W-1:0] serve_q;
`endif

    btn_edge #(.W(4)) u_btn_edge (
        .clk    (clk),
        .reset  (reset),
        .btn_i  ({btn2, btn1}),
        .rise_o (rise_s)
    );

    assign start_s = |rise_s;
    assign miss_s  = miss_l | miss_r;

    // Post-miss scores and lives; both sides may score in one cycle but only one ball is lost
    always_comb begin
        score1_d = score1_q;
        score2_d = score2_q;
        if (miss_r && (score1_q != SCORE_MAX)) begin
            score1_d = score1_q + SCORE_W'(1);
        end else begin
            score1_d = score1_q;
        end
        if (miss_l && (score2_q != SCORE_MAX)) begin
            score2_d = score2_q + SCORE_W'(1);
        end else begin
            score2_d = score2_q;
        end
        balls_d    = balls_q - 4'd1;
        end_game_s = (balls_d == 4'd0) || (score1_d >= SCORE_WIN) || (score2_d >= SCORE_WIN);
    end

    // Game sequencer with all outputs held in registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_NEWGAME;
            gra_still_q <= 1'b1;
            score1_q    <= '0;
            score2_q    <= '0;
            balls_q     <= 4'(BALLS);
            winner_q    <= WIN_NONE;
            hit_cnt_q   <= 8'd0;
            over_q      <= '0;
`ifdef PONG_AUTO_SERVE_EN
            serve_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_NEWGAME: begin
                    if (start_s) begin
                        state_q     <= ST_PLAY;
                        gra_still_q <= 1'b0;
                        score1_q    <= '0;
                        score2_q    <= '0;
                        balls_q     <= 4'(BALLS);
                        winner_q    <= WIN_NONE;
                        hit_cnt_q   <= 8'd0;
                    end
                end
                ST_PLAY: begin
                    if (miss_s) begin
                        score1_q    <= score1_d;
                        score2_q    <= score2_d;
                        balls_q     <= balls_d;
                        gra_still_q <= 1'b1;
                        if (end_game_s) begin
                            state_q  <= ST_OVER;
                            over_q   <= '0;
                            winner_q <= judge_winner(16'(score1_d), 16'(score2_d));
                        end else begin
                            state_q   <= ST_SERVE;
                            hit_cnt_q <= 8'd0;
`ifdef PONG_AUTO_SERVE_EN
                            serve_q   <= '0;
`endif
                        end
                    end else if (hit && (hit_cnt_q != 8'hFF)) begin
                        hit_cnt_q <= hit_cnt_q + 8'd1;
                    end
                end
                ST_SERVE: begin
`ifdef PONG_AUTO_SERVE_EN
                    if (start_s || (serve_q == SERVE_W'(SERVE_CYCLES - 1))) begin
                        state_q     <= ST_PLAY;
                        gra_still_q <= 1'b0;
                    end else begin
                        serve_q <= serve_q + SERVE_W'(1);
                    end
`else
                    if (start_s) begin
                        state_q     <= ST_PLAY;
                        gra_still_q <= 1'b0;
                    end
`endif
                end
                ST_OVER: begin
                    if (over_q == OVER_W'(OVER_CYCLES - 1)) begin
                        state_q <= ST_NEWGAME;
                    end else begin
                        over_q <= over_q + OVER_W'(1);
                    end
                end
                default: begin
                    state_q     <= ST_NEWGAME;
                    gra_still_q <= 1'b1;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign gra_still  = gra_still_q;
    assign score1     = score1_q;
    assign score2     = score2_q;
    assign balls_left = balls_q;
    assign winner     = winner_q;
    assign hit_cnt    = hit_cnt_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: two parameterisations share one stimulus stream
// and are compared every cycle against a rule-level game model.
module tb_pong_game_ctrl;

    localparam int OC = 10;
    localparam int SC = 20;
    localparam int P_NEW = 0, P_PLAY = 1, P_SERVE = 2, P_OVER = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn1, btn2;
    logic       hit, miss_l, miss_r;

    logic [1:0] st [2];
    logic       gs [2];
    logic [3:0] sc1 [2];
    logic [3:0] sc2 [2];
    logic [3:0] bl [2];
    logic [1:0] wn [2];
    logic [7:0] hc [2];

    int total = 0;
    int bad   = 0;

    int m_balls_cfg [2] = '{3, 5};
    int m_win_cfg   [2] = '{9, 2};
    int m_ph [2], m_s1 [2], m_s2 [2], m_bl [2], m_hc [2], m_wn [2], m_ot [2], m_stt [2];
    logic [3:0] m_prev;
    logic       m_edge;

    always #5 clk = ~clk;

    pong_game_ctrl #(.BALLS(3), .SCORE_W(4), .WIN_SCORE(9), .OVER_CYCLES(OC), .SERVE_CYCLES(SC)) u_a (
        .clk(clk), .reset(reset), .btn1(btn1), .btn2(btn2), .hit(hit), .miss_l(miss_l), .miss_r(miss_r),
        .state(st[0]), .gra_still(gs[0]), .score1(sc1[0]), .score2(sc2[0]), .balls_left(bl[0]),
        .winner(wn[0]), .hit_cnt(hc[0]));

    pong_game_ctrl #(.BALLS(5), .SCORE_W(4), .WIN_SCORE(2), .OVER_CYCLES(OC), .SERVE_CYCLES(SC)) u_b (
        .clk(clk), .reset(reset), .btn1(btn1), .btn2(btn2), .hit(hit), .miss_l(miss_l), .miss_r(miss_r),
        .state(st[1]), .gra_still(gs[1]), .score1(sc1[1]), .score2(sc2[1]), .balls_left(bl[1]),
        .winner(wn[1]), .hit_cnt(hc[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Game rules applied to the inputs of the coming clock edge
    task automatic model_step();
        logic start;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_ph[i] = P_NEW; m_s1[i] = 0; m_s2[i] = 0; m_bl[i] = m_balls_cfg[i];
                m_hc[i] = 0; m_wn[i] = 0; m_ot[i] = 0; m_stt[i] = 0;
            end
            m_prev = 4'b0000;
            m_edge = 1'b0;
            return;
        end
        start  = m_edge;
        m_edge = |({btn2, btn1} & ~m_prev);
        m_prev = {btn2, btn1};
        for (int i = 0; i < 2; i++) begin
            case (m_ph[i])
                P_NEW: if (start) begin
                    m_s1[i] = 0; m_s2[i] = 0; m_hc[i] = 0; m_bl[i] = m_balls_cfg[i]; m_ph[i] = P_PLAY;
                end
                P_PLAY: if (miss_l || miss_r) begin
                    if (miss_r && m_s1[i] < 15) m_s1[i]++;
                    if (miss_l && m_s2[i] < 15) m_s2[i]++;
                    m_bl[i]--;
                    if (m_bl[i] == 0 || m_s1[i] >= m_win_cfg[i] || m_s2[i] >= m_win_cfg[i]) begin
                        m_ph[i] = P_OVER; m_ot[i] = 0;
                        m_wn[i] = (m_s1[i] > m_s2[i]) ? 1 : ((m_s2[i] > m_s1[i]) ? 2 : 3);
                    end else begin
                        m_ph[i] = P_SERVE; m_hc[i] = 0; m_stt[i] = 0;
                    end
                end else if (hit && m_hc[i] < 255) begin
                    m_hc[i]++;
                end
                P_SERVE: begin
                    if (start) m_ph[i] = P_PLAY;
`ifdef PONG_AUTO_SERVE_EN
                    else begin
                        m_stt[i]++;
                        if (m_stt[i] == SC) m_ph[i] = P_PLAY;
                    end
`endif
                end
                default: begin
                    m_ot[i]++;
                    if (m_ot[i] == OC) m_ph[i] = P_NEW;
                end
            endcase
        end
    endtask

    task automatic compare_all();
        string n;
        for (int i = 0; i < 2; i++) begin
            n = (i == 0) ? "a" : "b";
            chk({n, "_state"}, st[i], m_ph[i]);
            chk({n, "_still"}, gs[i], (m_ph[i] != P_PLAY) ? 1 : 0);
            chk({n, "_score1"}, sc1[i], m_s1[i]);
            chk({n, "_score2"}, sc2[i], m_s2[i]);
            chk({n, "_balls"}, bl[i], m_bl[i]);
            chk({n, "_hitcnt"}, hc[i], m_hc[i]);
            if (m_ph[i] == P_OVER) chk({n, "_winner"}, wn[i], m_wn[i]);
        end
    endtask

    task automatic step(input logic [1:0] b1, input logic [1:0] b2, input logic h, input logic l, input logic r);
        btn1 = b1; btn2 = b2; hit = h; miss_l = l; miss_r = r;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic press();
        step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        btn1 = 2'b01; btn2 = 2'b00; hit = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
        repeat (3) step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("rst_state", st[0], 0);
        chk("rst_balls_a", bl[0], 3);
        chk("rst_balls_b", bl[1], 5);
        chk("rst_still", gs[0], 1);
        reset = 1'b0;
        step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("rel1_state", st[0], 0);
        step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("rel2_state", st[0], 1);
        repeat (5) step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("held_state", st[0], 1);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // full game on the three-ball instance
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("g1_balls", bl[0], 2);
        chk("g1_state", st[0], 2);
        press();
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("g2_balls", bl[0], 1);
        press();
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("g3_state", st[0], 3);
        chk("g3_score2", sc2[0], 3);
        chk("g3_balls", bl[0], 0);
        chk("g3_winner", wn[0], 2);

        // OVER dwell with buttons pressed early in the hold
        n = 1;
        for (int k = 0; k < 50 && st[0] == 2'b11; k++) begin
            if (k < 5) step(2'($urandom), 2'($urandom), 1'b0, 1'b0, 1'b0);
            else step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
            if (st[0] == 2'b11) n++;
        end
        chk("over_dwell", n, OC);
        chk("over_exit", st[0], 0);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        press();
        chk("restart_state", st[0], 1);
        chk("restart_s1", sc1[0], 0);
        chk("restart_s2", sc2[0], 0);
        chk("restart_balls", bl[0], 3);

        // win-score limit on the five-ball instance
        do_reset();
        press();
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        press();
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("win_state", st[1], 3);
        chk("win_s1", sc1[1], 2);
        chk("win_balls", bl[1], 3);
        chk("win_winner", wn[1], 1);

        // double miss with a hit in the same cycle
        do_reset();
        press();
        repeat (3) step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("sim_pre_hc", hc[0], 3);
        step(2'b00, 2'b00, 1'b1, 1'b1, 1'b1);
        chk("sim_s1", sc1[0], 1);
        chk("sim_s2", sc2[0], 1);
        chk("sim_balls", bl[0], 2);
        chk("sim_state", st[0], 2);
        chk("sim_hc", hc[0], 0);

`ifdef PONG_AUTO_SERVE_EN
        n = 1;
        for (int k = 0; k < 60 && st[0] == 2'b10; k++) begin
            step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
            if (st[0] == 2'b10) n++;
        end
        chk("auto_dwell", n, SC);
        chk("auto_state", st[0], 1);
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        repeat (4) step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("early_serve_wait", st[0], 2);
        step(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("early_serve", st[0], 1);
`else
        repeat (40) step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("serve_waits", st[0], 2);
`endif

        // rally counter saturation
        do_reset();
        press();
        repeat (260) step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("hc_sat", hc[0], 255);

        // randomized play against the model
        for (int k = 0; k < 3000; k++) begin
            logic [1:0] b1, b2;
            b1 = ($urandom_range(0, 5) == 0) ? 2'($urandom) : btn1;
            b2 = ($urandom_range(0, 9) == 0) ? 2'($urandom) : btn2;
            reset = ($urandom_range(0, 499) == 0);
            step(b1, b2, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
